// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection,
// ACKed writes and master-terminated reads on an open-drain SDA.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, shift_in;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       rw_q, rw_d;
  // Marks "ACK phase already entered" (ADDR_ACK, READ_ACK) or "byte complete" (WRITE).
  logic       pend_q, pend_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  // Synchronisers reset to 1 so the bus looks idle coming out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign shift_in  = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    pend_d     = pend_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    unique case (state_q)
      StAddr: begin
        if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (shift_in[7:1] == SLAVE_ADDR) begin
              busy_d  = 1'b1;
              rw_d    = shift_in[0];
              pend_d  = 1'b0;
              state_d = StAddrAck;
              if (shift_in[0]) begin
                tx_shift_d = tx_data;
                tx_req_d   = 1'b1;
              end
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StAddrAck: begin
        if (scl_fall) begin
          if (!pend_q) begin
            sda_oe_d = 1'b1;
            pend_d   = 1'b1;
          end else begin
            pend_d = 1'b0;
            cnt_d  = 3'd0;
            if (rw_q) begin
              sda_oe_d = ~tx_shift_q[7];
              state_d  = StRead;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrite;
            end
          end
        end
      end
      StWrite: begin
        if (scl_rise && !pend_q) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            pend_d     = 1'b1;
          end
        end else if (scl_fall && pend_q) begin
          sda_oe_d = 1'b1;
          pend_d   = 1'b0;
          state_d  = StWriteAck;
        end
      end
      StWriteAck: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          cnt_d    = 3'd0;
          state_d  = StWrite;
        end
      end
      StRead: begin
        if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            pend_d   = 1'b0;
            state_d  = StReadAck;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            sda_oe_d   = ~tx_shift_q[6];
            cnt_d      = cnt_q + 3'd1;
          end
        end
      end
      StReadAck: begin
        if (scl_rise && !pend_q) begin
          if (!sda_s) begin
            tx_shift_d = tx_data;
            tx_req_d   = 1'b1;
            pend_d     = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end else if (scl_fall && pend_q) begin
          sda_oe_d = ~tx_shift_q[7];
          cnt_d    = 3'd0;
          pend_d   = 1'b0;
          state_d  = StRead;
        end
      end
      default: ;
    endcase

    // Bus conditions override data edges; a completed rx byte is still reported.
    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = 3'd0;
      pend_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      tx_req_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      pend_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      tx_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_shift_q <= 8'h00;
      rw_q       <= 1'b0;
      pend_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      pend_q     <= pend_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_req   = tx_req_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule
